// File: rtl/risc16_mem_pkg.sv
// Shared types for the risc16 memory arbiter: requester indices, byte-lane
// write-enable codes and the arbiter FSM states.
package risc16_mem_pkg;

  typedef enum logic [1:0] {
    REQ_HOST   = 2'd0,
    REQ_DATA   = 2'd1,
    REQ_IFETCH = 2'd2,
    REQ_NONE   = 2'd3
  } req_id_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ISSUED = 1'b1
  } arb_state_e;

  // Successor of a requester index in the mod-3 ring.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: ptr is the top-priority index, the search then
// ascends mod 3. Returns a one-hot grant and the pointer after that grant.
module rr_pick3
  import risc16_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] ptr_next
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        // Granted index drops to lowest priority.
        ptr_next = rr_next(idx);
        found    = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency word memory between host,
// CPU data and CPU ifetch ports. Define RISC16_ARB_PERFCNT_EN for perf counters.
module risc16_mem_arbiter
  import risc16_mem_pkg::*;
#(
  parameter int         MEM_AW     = 15,
  parameter logic [1:0] RESET_PRIO = 2'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic [15:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [15:0]       d_addr,
  input  logic [1:0]        d_we,
  input  logic [15:0]       d_wdata,
  output logic [15:0]       d_rdata,
  output logic              d_ack,
  input  logic              h_req,
  input  logic [15:0]       h_addr,
  input  logic [1:0]        h_we,
  input  logic [15:0]       h_wdata,
  output logic [15:0]       h_rdata,
  output logic              h_ack,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [1:0]        grant_id
`ifdef RISC16_ARB_PERFCNT_EN
  ,
  output logic [31:0]       perf_grant_i,
  output logic [31:0]       perf_grant_d,
  output logic [31:0]       perf_grant_h,
  output logic [31:0]       perf_wait_i
`endif
);

  arb_state_e  state;
  logic [1:0]  ptr;
  logic [1:0]  ptr_next;
  logic [2:0]  ack_q;
  logic [2:0]  req_vec;
  logic [2:0]  ack_mask;
  logic [2:0]  req_live;
  logic [2:0]  gnt;
  logic [15:0] sel_addr;
  logic [15:0] i_rdata_q;
  logic [15:0] d_rdata_q;
  logic [15:0] h_rdata_q;
  logic        unused_addr_lsb;

  assign req_vec = {i_req, d_req, h_req};

  // A port being acked still shows the completed request on req, so it sits
  // out this round. Reset suppresses new grants so nothing launches under rst.
  assign ack_mask = (state == ISSUED) ? ack_q : '0;
  assign req_live = req_vec & ~ack_mask & {3{~rst}};

  rr_pick3 u_pick (
    .req      (req_live),
    .ptr      (ptr),
    .gnt      (gnt),
    .ptr_next (ptr_next)
  );

  always_comb begin
    mem_en    = |gnt;
    mem_we    = WE_NONE;
    mem_wdata = '0;
    sel_addr  = '0;
    grant_id  = REQ_NONE;
    if (gnt[REQ_HOST]) begin
      mem_we    = h_we;
      mem_wdata = h_wdata;
      sel_addr  = h_addr;
      grant_id  = REQ_HOST;
    end else if (gnt[REQ_DATA]) begin
      mem_we    = d_we;
      mem_wdata = d_wdata;
      sel_addr  = d_addr;
      grant_id  = REQ_DATA;
    end else if (gnt[REQ_IFETCH]) begin
      sel_addr  = i_addr;
      grant_id  = REQ_IFETCH;
    end
  end

  assign mem_addr        = sel_addr[MEM_AW:1];
  assign unused_addr_lsb = sel_addr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= RESET_PRIO;
      ack_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state <= (|gnt) ? ISSUED : IDLE;
      ptr   <= ptr_next;
      ack_q <= gnt;
      if (ack_q[REQ_HOST])   h_rdata_q <= mem_rdata;
      if (ack_q[REQ_DATA])   d_rdata_q <= mem_rdata;
      if (ack_q[REQ_IFETCH]) i_rdata_q <= mem_rdata;
    end
  end

  // An access launched just before rst is dropped: its ack is hidden while
  // rst is high and cleared at the reset edge.
  assign h_ack = ack_q[REQ_HOST]   & ~rst;
  assign d_ack = ack_q[REQ_DATA]   & ~rst;
  assign i_ack = ack_q[REQ_IFETCH] & ~rst;

  assign h_rdata = h_ack ? mem_rdata : h_rdata_q;
  assign d_rdata = d_ack ? mem_rdata : d_rdata_q;
  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;

`ifdef RISC16_ARB_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_i <= '0;
      perf_grant_d <= '0;
      perf_grant_h <= '0;
      perf_wait_i  <= '0;
    end else begin
      if (gnt[REQ_IFETCH]) perf_grant_i <= perf_grant_i + 32'd1;
      if (gnt[REQ_DATA])   perf_grant_d <= perf_grant_d + 32'd1;
      if (gnt[REQ_HOST])   perf_grant_h <= perf_grant_h + 32'd1;
      if (i_req && !gnt[REQ_IFETCH] && !ack_q[REQ_IFETCH])
        perf_wait_i <= perf_wait_i + 32'd1;
    end
  end
`endif

endmodule

// File: doc/risc16_mem_arbiter.md
Name: risc16_mem_arbiter

Overview:
- Shares one single-port synchronous word memory (1-cycle read latency) among three requesters: CPU instruction fetch, CPU data port and a host/loader port.
- The host/loader port preloads images and dumps results.
- Sits between risc16ba (with stall on missing ack) and the on-chip BRAM.
- Round-robin arbitration with one access outstanding; big-endian byte lanes matching the CPU data port.

Parameters:
- MEM_AW, 15, word-address width; the byte address is {word_addr, 1'b0}.
- RESET_PRIO, 2'd1, requester index holding top priority after reset (0=host, 1=data, 2=ifetch).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request
- i_addr  in  16  fetch byte address; bit 0 ignored
- i_rdata  out  16  fetch data; valid when i_ack=1
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request
- d_addr  in  16  data byte address; bit 0 ignored
- d_we  in  2  byte writes; [1]=high byte (even addr, wdata[15:8]), [0]=low byte (odd addr, wdata[7:0]); 2'b00 = read
- d_wdata  in  16  data write value
- d_rdata  out  16  data read value; valid when d_ack=1
- d_ack  out  1  data completion pulse
- h_req, h_addr, h_we, h_wdata, h_rdata, h_ack: host port, same widths and semantics as the data port
- mem_en  out  1  memory access strobe
- mem_we  out  2  memory byte write enables, same lane mapping as d_we
- mem_addr  out  MEM_AW  memory word address = addr[MEM_AW:1]
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid the cycle after mem_en
- grant_id  out  2  requester index of the current mem_en access, 2'd3 when idle

Behaviour:
- Reset:
  - All ack outputs, mem_en and mem_we are 0; rdata outputs and mem_wdata are 0; grant_id=3.
  - Round-robin pointer set so RESET_PRIO is top priority, then ascending index mod 3.
  - An access in flight at reset is dropped: no ack.
- Handshake:
  - A requester raises req with stable addr/we/wdata and holds them until it sees ack.
  - The ack is registered and lasts exactly one cycle.
  - The requester may present a new request from the cycle after ack.
- Issue and latency:
  - Cycle N: arbiter grants one requester; mem_en=1 and mem_* are driven combinationally from the granted port's signals.
  - Cycle N+1: that port's ack=1 and rdata=mem_rdata (captured combinationally; held in a register if the ack is registered). Writes ack in the same way.
  - Latency is 1 cycle.
- States:
  - IDLE: no access outstanding. Any masked-in req triggers a grant → ISSUED; otherwise stay IDLE.
  - ISSUED: previous access completes this cycle (ack asserted). A new grant may be issued in the same cycle (stay ISSUED), else → IDLE.
- Masking: in the cycle a requester's ack is asserted, that requester is excluded from arbitration, because its req still reflects the completed request.
- Round robin:
  - After each grant, priority rotates so the granted index becomes lowest.
  - With all three continuously requesting, the grant order cycles without starvation.
- Throughput: one access per cycle across different requesters; a single requester sees one access every 2 cycles.
- Writes:
  - mem_we=we of the granted port; mem_wdata passed unchanged; lanes are not swapped.
  - A single-byte write leaves the other byte untouched (memory lane semantics).
- Non-granted ports: ack=0; rdata holds its last value.
- Address bit 0 is ignored on all ports. Addresses above 2^(MEM_AW+1)-1 wrap by truncation.
- A req dropped before ack is a protocol violation; the behaviour is undefined.

Optional Feature:
- Macro: RISC16_ARB_PERFCNT_EN.
- Defined:
  - Adds outputs perf_grant_i, perf_grant_d, perf_grant_h (32 bits each, +1 per grant) and perf_wait_i (32 bits, +1 per cycle i_req is high without grant and without ack).
  - Counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent, and arbitration is identical.

Decomposition:
- Package risc16_mem_pkg: requester index enum (REQ_HOST=0, REQ_DATA=1, REQ_IFETCH=2, REQ_NONE=3), lane constants (WE_HI=2'b10, WE_LO=2'b01, WE_WORD=2'b11), state enum {IDLE, ISSUED}.
- One sub-module: rr_pick3. Purely combinational; takes a 3-bit request mask and the rotating pointer, returns a one-hot grant and the next pointer.

Test Plan:
- Reset then host writes word 0xBEEF to 0xC000 (h_we=2'b11) → mem_en in the grant cycle, h_ack the next cycle; host read of 0xC000 returns 0xBEEF.
- Data write 0x12AB to 0x0200 with d_we=2'b01 over existing 0x5566 → a read returns 0x55AB; with d_we=2'b10 → 0x1266.
- i_req and d_req raised together after reset with RESET_PRIO=1 → data granted first (grant_id=1); ifetch granted the next cycle while d_ack=1; i_ack the following cycle.
- All three held high for 12 cycles → grant_id sequence strictly rotates (1,2,0,1,2,0...) with one grant per cycle and no requester acked twice in a row.
- Single requester i_req held continuously with new addresses 0x0000, 0x0002, 0x0004 → acks every second cycle with correct i_rdata; odd i_addr 0x0003 returns the word at 0x0002.
- rst asserted in the cycle after a d_req grant → no d_ack, all outputs at reset values next cycle; with RISC16_ARB_PERFCNT_EN defined, counters read 0.
